// File: rtl/kfmmc_card_command_responder.sv
// Card-side MMC/SD CMD line responder: receives 48-bit host command frames, checks CRC7 and
// framing, then serialises a 48- or 136-bit response after the NCR gap.
module kfmmc_card_command_responder #(
  parameter int NCR_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reset_state,
  input  logic         mmc_clk,
  input  logic         mmc_cmd_in,
  output logic         mmc_cmd_out,
  output logic         mmc_cmd_oe,
  output logic         command_valid,
  output logic [5:0]   command_index,
  output logic [31:0]  command_argument,
  output logic         command_crc_error,
  output logic         command_frame_error,
  input  logic         respond_request,
  input  logic         respond_none,
  input  logic [135:0] response_data,
  input  logic         response_long,
  input  logic         response_crc_enable,
  output logic         response_done,
  output logic         busy,
  output logic [2:0]   debug_state
);

  // respond_request/respond_none are single-cycle strobes honoured only while waiting for a response.
  typedef enum logic [2:0] {
    S_IDLE, S_RECV, S_CHECK, S_WAIT_RESP, S_NCR, S_SEND
  } state_t;

  state_t state, state_next;

  logic         clk_s1, clk_s2, clk_d, cmd_s1, cmd_s2;
  logic         rise, fall, start_bit;
  logic [46:0]  rx_shift;
  logic [47:0]  frame_in;
  logic [7:0]   bit_count;
  logic [5:0]   ncr_count;
  logic [7:0]   tx_count, tx_total;
  logic [135:0] tx_shift, tx_load;
  logic         tx_long;

  // MSB-first CRC7 (x^7+x^3+1, init 0); leading zeros leave it unchanged, so short
  // messages are zero-extended on the left.
  function automatic logic [6:0] crc7_120(input logic [119:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b0; clk_s2 <= 1'b0; clk_d <= 1'b0;
      cmd_s1 <= 1'b1; cmd_s2 <= 1'b1;
    end else begin
      clk_s1 <= mmc_clk;    clk_s2 <= clk_s1; clk_d <= clk_s2;
      cmd_s1 <= mmc_cmd_in; cmd_s2 <= cmd_s1;
    end
  end

  assign rise      = clk_s2 & ~clk_d;
  assign fall      = ~clk_s2 & clk_d;
  assign start_bit = rise & ~cmd_s2;
  assign frame_in  = {rx_shift, cmd_s2};
  assign tx_total  = tx_long ? 8'd136 : 8'd48;

  assign command_valid = (state == S_CHECK);
  assign busy          = (state != S_IDLE);
  assign debug_state   = state;

  always_comb begin
    tx_load = response_data;
    if (response_crc_enable) begin
      if (response_long)
        tx_load = {response_data[135:8], crc7_120(response_data[127:8]), 1'b1};
      else
        tx_load = {response_data[135:96], crc7_120({80'b0, response_data[135:96]}), 1'b1,
                   response_data[87:0]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (reset_state) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start_bit) state_next = S_RECV;
        S_RECV:      if (rise && bit_count == 8'd47) state_next = S_CHECK;
        S_CHECK:     state_next = S_WAIT_RESP;
        S_WAIT_RESP: begin
          if (respond_request)   state_next = S_NCR;
          else if (respond_none) state_next = S_IDLE;
          else if (start_bit)    state_next = S_RECV;
        end
        S_NCR:       if (fall && ncr_count == 6'(NCR_CYCLES - 1)) state_next = S_SEND;
        S_SEND:      if (fall && tx_count == tx_total) state_next = S_IDLE;
        default:     state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mmc_cmd_out         <= 1'b1;
      mmc_cmd_oe          <= 1'b0;
      command_index       <= '0;
      command_argument    <= '0;
      command_crc_error   <= 1'b0;
      command_frame_error <= 1'b0;
      response_done       <= 1'b0;
      rx_shift            <= '0;
      bit_count           <= '0;
      ncr_count           <= '0;
      tx_count            <= '0;
      tx_shift            <= '0;
      tx_long             <= 1'b0;
    end else begin
      response_done <= 1'b0;
      if (reset_state) begin
        mmc_cmd_oe          <= 1'b0;
        mmc_cmd_out         <= 1'b1;
        bit_count           <= '0;
        ncr_count           <= '0;
        tx_count            <= '0;
        command_crc_error   <= 1'b0;
        command_frame_error <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_bit) begin
            rx_shift  <= '0;
            bit_count <= 8'd1;
          end
          S_RECV: if (rise) begin
            rx_shift <= frame_in[46:0];
            if (bit_count != 8'd48) bit_count <= bit_count + 8'd1;
            // Decoded fields are captured with the last bit so they are valid alongside command_valid.
            if (bit_count == 8'd47) begin
              command_index       <= frame_in[45:40];
              command_argument    <= frame_in[39:8];
              command_crc_error   <= crc7_120({80'b0, frame_in[47:8]}) != frame_in[7:1];
              command_frame_error <= ~frame_in[46] | ~frame_in[0];
            end
          end
          S_WAIT_RESP: begin
            if (respond_request) begin
              tx_shift  <= tx_load;
              tx_long   <= response_long;
              ncr_count <= '0;
              tx_count  <= '0;
            end else if (!respond_none && start_bit) begin
              rx_shift  <= '0;
              bit_count <= 8'd1;
            end
          end
          S_NCR: if (fall) begin
            ncr_count  <= ncr_count + 6'd1;
            mmc_cmd_oe <= 1'b0;
          end
          S_SEND: if (fall) begin
            if (tx_count == tx_total) begin
              mmc_cmd_oe    <= 1'b0;
              mmc_cmd_out   <= 1'b1;
              response_done <= 1'b1;
            end else begin
              mmc_cmd_oe  <= 1'b1;
              mmc_cmd_out <= tx_shift[135];
              tx_shift    <= {tx_shift[134:0], 1'b0};
              tx_count    <= tx_count + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kfmmc_card_command_responder.sv
// Bench for kfmmc_card_command_responder: host-side driver, command and response-bit
// scoreboards, and a CRC7 reference computed by polynomial long division.
module tb_kfmmc_card_command_responder;
  localparam int NCR  = 2;
  localparam int HALF = 40;

  logic         clock = 1'b0;
  logic         reset, reset_state, mmc_clk, mmc_cmd_in;
  logic         mmc_cmd_out, mmc_cmd_oe, command_valid;
  logic [5:0]   command_index;
  logic [31:0]  command_argument;
  logic         command_crc_error, command_frame_error;
  logic         respond_request, respond_none;
  logic [135:0] response_data;
  logic         response_long, response_crc_enable;
  logic         response_done, busy;
  logic [2:0]   debug_state;

  kfmmc_card_command_responder #(.NCR_CYCLES(NCR)) dut (
    .clock(clock), .reset(reset), .reset_state(reset_state),
    .mmc_clk(mmc_clk), .mmc_cmd_in(mmc_cmd_in),
    .mmc_cmd_out(mmc_cmd_out), .mmc_cmd_oe(mmc_cmd_oe),
    .command_valid(command_valid), .command_index(command_index),
    .command_argument(command_argument), .command_crc_error(command_crc_error),
    .command_frame_error(command_frame_error),
    .respond_request(respond_request), .respond_none(respond_none),
    .response_data(response_data), .response_long(response_long),
    .response_crc_enable(response_crc_enable), .response_done(response_done),
    .busy(busy), .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_err;
    logic        frame_err;
  } cmd_t;

  cmd_t       exp_cmd_q[$];
  logic [0:0] exp_q[$];
  cmd_t       mon_cmd;
  int         tests_run = 0;
  int         tests_failed = 0;
  int         done_seen = 0;
  int         exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of msg*x^7 divided by x^7+x^3+1 over GF(2).
  function automatic logic [6:0] ref_crc(input logic [119:0] msg);
    logic [126:0] r;
    r = {msg, 7'b0};
    for (int i = 126; i >= 7; i--)
      if (r[i]) r = r ^ (127'h89 << (i - 7));
    return r[6:0];
  endfunction

  // Command scoreboard.
  always @(negedge clock) begin
    if (!reset && command_valid) begin
      if (exp_cmd_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL cmd_unexpected: got index %0d expected no command", command_index);
      end else begin
        mon_cmd = exp_cmd_q.pop_front();
        check("cmd_index", 64'(command_index), 64'(mon_cmd.idx));
        check("cmd_argument", 64'(command_argument), 64'(mon_cmd.arg));
        check("cmd_crc_error", 64'(command_crc_error), 64'(mon_cmd.crc_err));
        check("cmd_frame_error", 64'(command_frame_error), 64'(mon_cmd.frame_err));
        check("cmd_busy", 64'(busy), 64'd1);
      end
    end
  end

  // Response bit scoreboard: host samples CMD on the rising edge of mmc_clk.
  always @(posedge mmc_clk) begin
    if (mmc_cmd_oe) begin
      if (exp_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL resp_unexpected: got driven bit %0d expected line released", mmc_cmd_out);
      end else begin
        check("resp_bit", 64'(mmc_cmd_out), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clock) if (!reset && response_done) done_seen++;

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      mmc_cmd_in = f[i];
      #HALF mmc_clk = 1'b1;
      #HALF mmc_clk = 1'b0;
    end
    mmc_cmd_in = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic host_command(input logic [47:0] f);
    cmd_t c;
    c.idx       = f[45:40];
    c.arg       = f[39:8];
    c.crc_err   = ref_crc({80'b0, f[47:8]}) != f[7:1];
    c.frame_err = !f[46] || !f[0];
    exp_cmd_q.push_back(c);
    send_frame(f);
  endtask

  task automatic mmc_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      #HALF mmc_clk = 1'b1;
      #HALF mmc_clk = 1'b0;
    end
  endtask

  task automatic strobe_none();
    @(negedge clock) respond_none = 1'b1;
    @(negedge clock) respond_none = 1'b0;
    repeat (2) @(negedge clock);
    check("none_busy", 64'(busy), 64'd0);
  endtask

  // abort_at < 0: full response; otherwise reset_state after abort_at bits were seen.
  task automatic respond(input logic [135:0] data, input logic lng, input logic crc_en,
                         input int abort_at);
    logic [135:0] f;
    int nbits;
    nbits = lng ? 136 : 48;
    f = lng ? data : {88'b0, data[135:88]};
    if (crc_en) begin
      if (lng) f[7:1] = ref_crc(f[127:8]);
      else     f[7:1] = ref_crc({80'b0, f[47:8]});
      f[0] = 1'b1;
    end
    for (int i = nbits - 1; i >= 0; i--) exp_q.push_back(f[i]);
    @(negedge clock);
    response_data = data; response_long = lng; response_crc_enable = crc_en;
    respond_request = 1'b1;
    @(negedge clock);
    respond_request = 1'b0;
    response_data = {$urandom, $urandom, $urandom, $urandom, 8'($urandom)};
    response_long = ~lng; response_crc_enable = ~crc_en;
    for (int k = 1; k <= NCR + 1; k++) begin
      #HALF mmc_clk = 1'b1;
      check("ncr_gap_oe", 64'(mmc_cmd_oe), 64'd0);
      #HALF mmc_clk = 1'b0;
    end
    if (abort_at < 0) begin
      mmc_pulses(nbits + 1);
      repeat (6) @(negedge clock);
      exp_done++;
      check("resp_done_count", 64'(done_seen), 64'(exp_done));
      check("resp_busy_after", 64'(busy), 64'd0);
      check("resp_bits_left", 64'(exp_q.size()), 64'd0);
    end else begin
      mmc_pulses(abort_at);
      @(negedge clock) reset_state = 1'b1;
      @(negedge clock) reset_state = 1'b0;
      check("abort_oe", 64'(mmc_cmd_oe), 64'd0);
      check("abort_out", 64'(mmc_cmd_out), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      exp_q.delete();
      mmc_pulses(6);
      repeat (6) @(negedge clock);
      check("abort_no_done", 64'(done_seen), 64'(exp_done));
    end
  endtask

  initial begin
    logic [47:0] f;
    int act;
    reset = 1'b1; reset_state = 1'b0; mmc_clk = 1'b0; mmc_cmd_in = 1'b1;
    respond_request = 1'b0; respond_none = 1'b0; response_data = '0;
    response_long = 1'b0; response_crc_enable = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_cmd_out", 64'(mmc_cmd_out), 64'd1);
    check("rst_cmd_oe", 64'(mmc_cmd_oe), 64'd0);
    check("rst_valid", 64'(command_valid), 64'd0);
    check("rst_index", 64'(command_index), 64'd0);
    check("rst_argument", 64'(command_argument), 64'd0);
    check("rst_crc_error", 64'(command_crc_error), 64'd0);
    check("rst_frame_error", 64'(command_frame_error), 64'd0);
    check("rst_done", 64'(response_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    host_command(48'h400000000095);
    respond({48'h400000000000, 88'b0}, 1'b0, 1'b1, -1);
    host_command(48'h48000001AA89);
    strobe_none();
    host_command(48'h48000001AA86);
    strobe_none();
    host_command(48'h400000000095);
    respond({8'h3F, {16{8'hA5}}}, 1'b1, 1'b0, -1);

    // Next command arrives while a response is pending: both decode, nothing is driven.
    host_command(48'h48000001AA87);
    host_command(48'h400000000095);
    strobe_none();
    check("overrun_no_done", 64'(done_seen), 64'(exp_done));

    host_command(48'h400000000095);
    respond({48'h400000000000, 88'b0}, 1'b0, 1'b1, 20);
    host_command(48'h400000000095);
    strobe_none();

    // Request outside the wait window must be ignored.
    @(negedge clock) respond_request = 1'b1;
    @(negedge clock) respond_request = 1'b0;
    mmc_pulses(4);
    check("idle_request_busy", 64'(busy), 64'd0);

    for (int n = 0; n < 10; n++) begin
      f[47]    = 1'b0;
      f[46]    = ($urandom_range(0, 7) != 0);
      f[45:40] = 6'($urandom_range(0, 63));
      f[39:8]  = $urandom;
      f[7:1]   = ($urandom_range(0, 3) != 0) ? ref_crc({80'b0, f[47:8]}) : 7'($urandom);
      f[0]     = ($urandom_range(0, 7) != 0);
      host_command(f);
      act = $urandom_range(0, 2);
      if (act == 0)
        strobe_none();
      else
        respond({$urandom, $urandom, $urandom, $urandom, 8'($urandom)}, act == 2,
                1'($urandom_range(0, 1)), -1);
    end

    repeat (10) @(negedge clock);
    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("final_done_count", 64'(done_seen), 64'(exp_done));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
